// File: rtl/md_issue_ctrl.sv
// Issue controller for the multiply/divide unit: latches the request, pulses the start,
// stalls the pipeline until the result or a timeout arrives, then writes back once.
module md_issue_ctrl #(
  parameter int TIMEOUT         = 40,
  parameter int RSTATUS_REG     = 30,
  parameter int RSTATUS_MULT    = 4,
  parameter int RSTATUS_DIV     = 5,
  parameter int RSTATUS_TIMEOUT = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_mult,
  input  logic        req_div,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic [4:0]  dest,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        md_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   opa_q, opa_d;
  logic [31:0]   opb_q, opb_d;
  logic [4:0]    dest_q, dest_d;
  logic          mult_q, mult_d;
  logic [31:0]   res_q, res_d;
  logic          exc_q, exc_d;
  logic          tmo_q, tmo_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      dest_q  <= '0;
      mult_q  <= 1'b0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      dest_q  <= dest_d;
      mult_q  <= mult_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    dest_d     = dest_q;
    mult_d     = mult_q;
    res_d      = res_q;
    exc_d      = exc_q;
    tmo_d      = tmo_q;
    ctrl_MULT  = 1'b0;
    ctrl_DIV   = 1'b0;
    stall      = 1'b0;
    wb_valid   = 1'b0;
    wb_reg     = '0;
    wb_data    = '0;
    md_timeout = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_mult || req_div) begin
          opa_d   = opA;
          opb_d   = opB;
          dest_d  = dest;
          mult_d  = req_mult;
          stall   = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // ready may still be high from the previous op, so it is not looked at here
        ctrl_MULT = mult_q;
        ctrl_DIV  = !mult_q;
        stall     = 1'b1;
        cnt_d     = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (md_resultRDY) begin
          res_d   = md_result;
          exc_d   = md_exception;
          tmo_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          exc_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (tmo_q) begin
          wb_valid   = 1'b1;
          wb_reg     = 5'(RSTATUS_REG);
          wb_data    = 32'(RSTATUS_TIMEOUT);
          md_timeout = 1'b1;
        end else if (exc_q) begin
          wb_valid = 1'b1;
          wb_reg   = 5'(RSTATUS_REG);
          wb_data  = mult_q ? 32'(RSTATUS_MULT) : 32'(RSTATUS_DIV);
        end else begin
          wb_valid = (dest_q != 5'd0);
          wb_reg   = dest_q;
          wb_data  = res_q;
        end
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign md_operandA = opa_q;
  assign md_operandB = opb_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl; the multdiv unit is played by hand-timed ready pulses.
module tb_md_issue_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_mult, req_div;
  logic [31:0] opA, opB;
  logic [4:0]  dest;
  logic [31:0] md_result;
  logic        md_exception, md_resultRDY;
  logic [31:0] md_operandA, md_operandB;
  logic        ctrl_MULT, ctrl_DIV, stall, wb_valid, md_timeout;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  int total = 0;
  int bad   = 0;

  // observations collected by run_op for one operation
  int          n_cm, n_cd, cm_cyc, cd_cyc, n_stall, n_wb, n_tmo, done_cyc;
  logic        acc_stall;
  logic [4:0]  wb_reg_seen;
  logic [31:0] wb_data_seen, opa_seen, opb_seen;

  md_issue_ctrl dut (
    .clock(clock), .reset(reset),
    .req_mult(req_mult), .req_div(req_div),
    .opA(opA), .opB(opB), .dest(dest),
    .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
    .md_operandA(md_operandA), .md_operandB(md_operandB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .stall(stall),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .md_timeout(md_timeout)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives one op starting in an IDLE cycle; cycle 0 = accept, 1 = ISSUE, 2.. = WAIT.
  // rdy_at < 0 means the unit never answers. Returns one cycle after DONE.
  task automatic run_op(input logic rm, input logic rd, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input int rdy_at, input logic [31:0] res,
                        input logic exc, input logic stale);
    n_cm = 0; n_cd = 0; cm_cyc = -1; cd_cyc = -1; n_stall = 0; n_wb = 0; n_tmo = 0;
    done_cyc = -1; acc_stall = 1'b0; wb_reg_seen = '0; wb_data_seen = '0;
    opa_seen = '0; opb_seen = '0;
    req_mult = rm; req_div = rd; opA = a; opB = b; dest = d;
    for (int cyc = 0; cyc < 100 && done_cyc < 0; cyc++) begin
      if (cyc == 1) begin
        req_mult = 1'b0; req_div = 1'b0;
        opA = 32'hFFFF_FFFF; opB = 32'hFFFF_FFFF; dest = 5'd31;
      end
      if (stale && cyc <= 1) begin
        md_resultRDY = 1'b1; md_result = 32'hDEAD_BEEF; md_exception = 1'b0;
      end else if (cyc == rdy_at) begin
        md_resultRDY = 1'b1; md_result = res; md_exception = exc;
      end else begin
        md_resultRDY = 1'b0; md_result = '0; md_exception = 1'b0;
      end
      #1;
      if (cyc == 0) acc_stall = stall;
      if (stall) n_stall++;
      if (ctrl_MULT) begin n_cm++; cm_cyc = cyc; opa_seen = md_operandA; opb_seen = md_operandB; end
      if (ctrl_DIV)  begin n_cd++; cd_cyc = cyc; opa_seen = md_operandA; opb_seen = md_operandB; end
      if (wb_valid) begin n_wb++; wb_reg_seen = wb_reg; wb_data_seen = wb_data; end
      if (md_timeout) n_tmo++;
      if (cyc > 0 && !stall) done_cyc = cyc;
      @(posedge clock);
      #1;
    end
    md_resultRDY = 1'b0; md_exception = 1'b0; md_result = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_mult = 0; req_div = 0; opA = 32'h1234; opB = 32'h5678; dest = 5'd4;
    md_result = 32'h55; md_exception = 1'b0; md_resultRDY = 1'b0;
    tick(); tick();
    total++;
    if ({stall, ctrl_MULT, ctrl_DIV, wb_valid, md_timeout} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=00000", {stall, ctrl_MULT, ctrl_DIV, wb_valid, md_timeout});
    end
    total++;
    if ({md_operandA, md_operandB, wb_data, wb_reg} !== 101'b0) begin
      bad++; $display("FAIL reset_data got opA=%0h opB=%0h wb_data=%0h wb_reg=%0d exp all 0",
                      md_operandA, md_operandB, wb_data, wb_reg);
    end
    reset = 1'b0;
    tick();
    // a ready pulse while idle must be ignored
    md_resultRDY = 1'b1; md_result = 32'd99;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (wb_valid !== 1'b0 || stall !== 1'b0) begin
        bad++; $display("FAIL idle_rdy_ignored got wb_valid=%b stall=%b exp 0 0", wb_valid, stall);
      end
      tick();
    end
    md_resultRDY = 1'b0; md_result = '0;
    tick();
  endtask

  task automatic test_mult();
    run_op(1'b1, 1'b0, 32'd7, 32'd6, 5'd5, 18, 32'd42, 1'b0, 1'b0);
    total++;
    if (acc_stall !== 1'b1) begin bad++; $display("FAIL mult_accept_stall got=%b exp=1", acc_stall); end
    total++;
    if (n_cm != 1 || cm_cyc != 1 || n_cd != 0) begin
      bad++; $display("FAIL mult_ctrl got n_mult=%0d at=%0d n_div=%0d exp 1 1 0", n_cm, cm_cyc, n_cd);
    end
    total++;
    if (opa_seen !== 32'd7 || opb_seen !== 32'd6) begin
      bad++; $display("FAIL mult_operands got=%0d,%0d exp=7,6", opa_seen, opb_seen);
    end
    total++;
    if (done_cyc != 19 || n_stall != 19) begin
      bad++; $display("FAIL mult_timing got done=%0d stall_cycles=%0d exp 19 19", done_cyc, n_stall);
    end
    total++;
    if (n_wb != 1 || wb_reg_seen !== 5'd5 || wb_data_seen !== 32'd42 || n_tmo != 0) begin
      bad++; $display("FAIL mult_wb got n=%0d reg=%0d data=%0d tmo=%0d exp 1 5 42 0",
                      n_wb, wb_reg_seen, wb_data_seen, n_tmo);
    end
  endtask

  task automatic test_div_by_zero();
    run_op(1'b0, 1'b1, 32'd10, 32'd0, 5'd3, 5, 32'd0, 1'b1, 1'b0);
    total++;
    if (n_cd != 1 || cd_cyc != 1 || n_cm != 0) begin
      bad++; $display("FAIL div0_ctrl got n_div=%0d at=%0d n_mult=%0d exp 1 1 0", n_cd, cd_cyc, n_cm);
    end
    total++;
    if (done_cyc != 6 || n_wb != 1 || wb_reg_seen !== 5'd30 || wb_data_seen !== 32'd5) begin
      bad++; $display("FAIL div0_wb got done=%0d n=%0d reg=%0d data=%0d exp 6 1 30 5",
                      done_cyc, n_wb, wb_reg_seen, wb_data_seen);
    end
  endtask

  task automatic test_mult_exception();
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'd4, 5'd8, 3, 32'd0, 1'b1, 1'b0);
    total++;
    if (n_wb != 1 || wb_reg_seen !== 5'd30 || wb_data_seen !== 32'd4) begin
      bad++; $display("FAIL mult_exc_wb got n=%0d reg=%0d data=%0d exp 1 30 4", n_wb, wb_reg_seen, wb_data_seen);
    end
  endtask

  task automatic test_timeout();
    run_op(1'b0, 1'b1, 32'd100, 32'd7, 5'd11, -1, 32'd0, 1'b0, 1'b0);
    total++;
    if (done_cyc != 42 || n_stall != 42) begin
      bad++; $display("FAIL timeout_timing got done=%0d stall_cycles=%0d exp 42 42", done_cyc, n_stall);
    end
    total++;
    if (n_tmo != 1 || n_wb != 1 || wb_reg_seen !== 5'd30 || wb_data_seen !== 32'd6) begin
      bad++; $display("FAIL timeout_wb got tmo=%0d n=%0d reg=%0d data=%0d exp 1 1 30 6",
                      n_tmo, n_wb, wb_reg_seen, wb_data_seen);
    end
  endtask

  task automatic test_stale_ready();
    run_op(1'b1, 1'b0, 32'd3, 32'd33, 5'd12, 8, 32'd99, 1'b0, 1'b1);
    total++;
    if (done_cyc != 9 || n_wb != 1 || wb_reg_seen !== 5'd12 || wb_data_seen !== 32'd99) begin
      bad++; $display("FAIL stale_ready got done=%0d n=%0d reg=%0d data=%0h exp 9 1 12 63",
                      done_cyc, n_wb, wb_reg_seen, wb_data_seen);
    end
  endtask

  task automatic test_both_req();
    run_op(1'b1, 1'b1, 32'd2, 32'd3, 5'd1, 4, 32'd6, 1'b0, 1'b0);
    total++;
    if (n_cm != 1 || n_cd != 0 || wb_reg_seen !== 5'd1 || wb_data_seen !== 32'd6) begin
      bad++; $display("FAIL both_req got n_mult=%0d n_div=%0d reg=%0d data=%0d exp 1 0 1 6",
                      n_cm, n_cd, wb_reg_seen, wb_data_seen);
    end
  endtask

  task automatic test_reset_mid_op();
    req_div = 1'b1; opA = 32'd123; opB = 32'd4; dest = 5'd7;
    tick();
    req_div = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    // now in the 5th WAIT cycle
    reset = 1'b1;
    #1;
    total++;
    if ({stall, ctrl_MULT, ctrl_DIV, wb_valid, md_timeout} !== 5'b0 ||
        {md_operandA, md_operandB, wb_data, wb_reg} !== 101'b0) begin
      bad++; $display("FAIL reset_mid_op got stall=%b wb_valid=%b opA=%0h opB=%0h wb_data=%0h exp all 0",
                      stall, wb_valid, md_operandA, md_operandB, wb_data);
    end
    tick();
    reset = 1'b0;
    tick();
    md_resultRDY = 1'b1; md_result = 32'd30;
    n_wb = 0; n_stall = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (wb_valid) n_wb++;
      if (stall) n_stall++;
      tick();
      md_resultRDY = 1'b0; md_result = '0;
    end
    total++;
    if (n_wb != 0 || n_stall != 0) begin
      bad++; $display("FAIL late_rdy_after_reset got wb=%0d stall=%0d exp 0 0", n_wb, n_stall);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] num, den, quo;
    run_op(1'b1, 1'b0, 32'd11, 32'd7, 5'd0, 3, 32'd77, 1'b0, 1'b0);
    total++;
    if (done_cyc != 4 || n_wb != 0) begin
      bad++; $display("FAIL dest0_no_wb got done=%0d n_wb=%0d exp 4 0", done_cyc, n_wb);
    end
    num = 32'd8; den = 32'd2; quo = num / den;
    run_op(1'b0, 1'b1, num, den, 5'd9, 6, quo, 1'b0, 1'b0);
    total++;
    if (acc_stall !== 1'b1 || cd_cyc != 1) begin
      bad++; $display("FAIL b2b_accept got stall=%b div_at=%0d exp 1 1", acc_stall, cd_cyc);
    end
    total++;
    if (n_wb != 1 || wb_reg_seen !== 5'd9 || wb_data_seen !== 32'd4 || done_cyc != 7) begin
      bad++; $display("FAIL b2b_wb got n=%0d reg=%0d data=%0d done=%0d exp 1 9 4 7",
                      n_wb, wb_reg_seen, wb_data_seen, done_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div_by_zero();
    test_mult_exception();
    test_timeout();
    test_stale_ready();
    test_both_req();
    test_reset_mid_op();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
